// File: rtl/output_channel_issue_scheduler_if.sv
// Issue/credit bus between the trigger-issue stage, the output channel buffers
// and output_channel_issue_scheduler.
interface output_channel_issue_scheduler_if #(
  parameter int unsigned NUM_OUTPUT_CHANNELS = 4,
  parameter int unsigned COUNT_WIDTH         = 3,
  parameter int unsigned PIPELINE_DEPTH      = 2
);
  logic                                              issue_request;
  logic [NUM_OUTPUT_CHANNELS-1:0]                    issue_oci;
  logic                                              issue_grant;
  logic                                              pipeline_stall;
  logic                                              quash;
  logic [NUM_OUTPUT_CHANNELS-1:0]                    output_channel_dequeue;
  logic [NUM_OUTPUT_CHANNELS-1:0][COUNT_WIDTH-1:0]   output_channel_counts;
  logic [NUM_OUTPUT_CHANNELS-1:0]                    output_channel_full_status;
  logic [PIPELINE_DEPTH-1:0]                         in_flight_valid;

  modport master (
    output issue_request, issue_oci, pipeline_stall, quash, output_channel_dequeue,
    input  issue_grant, output_channel_counts, output_channel_full_status, in_flight_valid
  );

  modport slave (
    input  issue_request, issue_oci, pipeline_stall, quash, output_channel_dequeue,
    output issue_grant, output_channel_counts, output_channel_full_status, in_flight_valid
  );
endinterface

// File: rtl/output_channel_issue_scheduler.sv
// Credit-based issue scheduler for PE output channels: grants an issue only if every
// targeted channel has room counting committed entries plus in-flight writes.
// Optional same-cycle dequeue credit bypass: define OUTPUT_CHANNEL_DEQUEUE_BYPASS_EN.
module output_channel_issue_scheduler #(
  parameter int unsigned NUM_OUTPUT_CHANNELS = 4,
  parameter int unsigned FIFO_DEPTH          = 4,
  parameter int unsigned COUNT_WIDTH         = 3,
  parameter int unsigned PIPELINE_DEPTH      = 2
) (
  input logic                            clock,
  input logic                            reset,
  output_channel_issue_scheduler_if.slave bus
);
  localparam int unsigned EW = COUNT_WIDTH + 1;
  localparam logic [EW-1:0] DEPTH = EW'(FIFO_DEPTH);

  logic [NUM_OUTPUT_CHANNELS-1:0][COUNT_WIDTH-1:0] occupancy;
  logic [NUM_OUTPUT_CHANNELS-1:0][COUNT_WIDTH-1:0] occupancy_next;
  logic [PIPELINE_DEPTH-1:0][NUM_OUTPUT_CHANNELS-1:0] stage;
  logic [NUM_OUTPUT_CHANNELS-1:0][EW-1:0] effective;
  logic [NUM_OUTPUT_CHANNELS-1:0][EW-1:0] grant_level;
  logic [NUM_OUTPUT_CHANNELS-1:0] pop;
  logic [NUM_OUTPUT_CHANNELS-1:0] retire;
  logic [NUM_OUTPUT_CHANNELS-1:0] full;
  logic [PIPELINE_DEPTH-1:0] stage_valid;
  logic advance;
  logic fits;
  logic grant;

  always_comb begin
    advance = reset && !bus.pipeline_stall && !bus.quash;
    retire  = advance ? stage[PIPELINE_DEPTH-1] : '0;
    fits    = 1'b1;
    for (int unsigned i = 0; i < NUM_OUTPUT_CHANNELS; i++) begin
      pop[i]       = bus.output_channel_dequeue[i] && (occupancy[i] != '0);
      effective[i] = EW'(occupancy[i]);
      for (int unsigned k = 0; k < PIPELINE_DEPTH; k++) begin
        effective[i] = effective[i] + EW'(stage[k][i]);
      end
      full[i] = (effective[i] >= DEPTH);
`ifdef OUTPUT_CHANNEL_DEQUEUE_BYPASS_EN
      grant_level[i] = effective[i] - EW'(pop[i]);
`else
      grant_level[i] = effective[i];
`endif
      if (bus.issue_oci[i] && (grant_level[i] >= DEPTH)) begin
        fits = 1'b0;
      end
      // A retire and a pop on the same edge cancel out.
      occupancy_next[i] = occupancy[i];
      if (retire[i] && !pop[i]) begin
        occupancy_next[i] = occupancy[i] + COUNT_WIDTH'(1);
      end else if (pop[i] && !retire[i]) begin
        occupancy_next[i] = occupancy[i] - COUNT_WIDTH'(1);
      end
    end
    grant = bus.issue_request && advance && fits;
  end

  always_comb begin
    stage_valid = '0;
    for (int unsigned k = 0; k < PIPELINE_DEPTH; k++) begin
      stage_valid[k] = |stage[k];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      occupancy <= '0;
      stage     <= '0;
    end else begin
      occupancy <= occupancy_next;
      if (bus.quash) begin
        stage <= '0;
      end else if (!bus.pipeline_stall) begin
        stage[0] <= grant ? bus.issue_oci : '0;
        for (int unsigned k = 1; k < PIPELINE_DEPTH; k++) begin
          stage[k] <= stage[k-1];
        end
      end
    end
  end

  assign bus.issue_grant                = grant;
  assign bus.output_channel_counts      = occupancy;
  assign bus.output_channel_full_status = full;
  assign bus.in_flight_valid            = stage_valid;
endmodule

// File: tb/tb_output_channel_issue_scheduler.sv
// Directed self-checking bench for output_channel_issue_scheduler (4 channels,
// depth 4, 2 pipeline stages); expected values are hand-derived.
module tb_output_channel_issue_scheduler;
  localparam int unsigned N  = 4;
  localparam int unsigned FD = 4;
  localparam int unsigned CW = 3;
  localparam int unsigned PD = 2;
`ifdef OUTPUT_CHANNEL_DEQUEUE_BYPASS_EN
  localparam logic BYP_GRANT = 1'b1;
`else
  localparam logic BYP_GRANT = 1'b0;
`endif

  logic clock;
  logic reset;
  int compared;
  int mismatched;

  output_channel_issue_scheduler_if #(
    .NUM_OUTPUT_CHANNELS(N), .COUNT_WIDTH(CW), .PIPELINE_DEPTH(PD)
  ) bus ();

  output_channel_issue_scheduler #(
    .NUM_OUTPUT_CHANNELS(N), .FIFO_DEPTH(FD), .COUNT_WIDTH(CW), .PIPELINE_DEPTH(PD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic req, input logic [3:0] oci, input logic stall,
                       input logic q, input logic [3:0] deq);
    bus.issue_request          = req;
    bus.issue_oci              = oci;
    bus.pipeline_stall         = stall;
    bus.quash                  = q;
    bus.output_channel_dequeue = deq;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);

    // Reset with random inputs
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 4'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
      #1;
      check("rst_grant", 32'(bus.issue_grant), 32'd0);
      tick();
    end
    check("rst_counts", 32'(bus.output_channel_counts), 32'd0);
    check("rst_full", 32'(bus.output_channel_full_status), 32'd0);
    check("rst_ifv", 32'(bus.in_flight_valid), 32'd0);
    reset = 1'b1;
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);

    // Fill channel 0 with back-to-back requests
    for (int t = 0; t < 6; t++) begin
      drive(1'b1, 4'b0001, 1'b0, 1'b0, 4'b0000);
      #1;
      check("fill_grant", 32'(bus.issue_grant), (t < 4) ? 32'd1 : 32'd0);
      if (t == 3) check("fill_full_t3", 32'(bus.output_channel_full_status[0]), 32'd0);
      if (t == 4) check("fill_full_t4", 32'(bus.output_channel_full_status[0]), 32'd1);
      if (t == 5) check("fill_cnt_t5", 32'(bus.output_channel_counts[0]), 32'd3);
      tick();
    end
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
    #1;
    check("fill_cnt_t6", 32'(bus.output_channel_counts[0]), 32'd4);
    tick();
    check("fill_cnt_t7", 32'(bus.output_channel_counts[0]), 32'd4);

    // Drain channel 0, fill channel 1, multicast blocked by channel 1
    for (int t = 0; t < 4; t++) begin
      drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001);
      tick();
    end
    check("drain0_counts", 32'(bus.output_channel_counts), 32'd0);
    for (int t = 0; t < 4; t++) begin
      drive(1'b1, 4'b0010, 1'b0, 1'b0, 4'b0000);
      #1;
      check("fill1_grant", 32'(bus.issue_grant), 32'd1);
      tick();
    end
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
    tick();
    tick();
    check("fill1_cnt", 32'(bus.output_channel_counts[1]), 32'd4);
    check("fill1_full", 32'(bus.output_channel_full_status), 32'b0010);
    drive(1'b1, 4'b0011, 1'b0, 1'b0, 4'b0000);
    #1;
    check("mcast_grant", 32'(bus.issue_grant), 32'd0);
    tick();
    check("mcast_cnt0", 32'(bus.output_channel_counts[0]), 32'd0);
    check("mcast_ifv", 32'(bus.in_flight_valid), 32'd0);
    drive(1'b1, 4'b0001, 1'b0, 1'b0, 4'b0000);
    #1;
    check("ch0_grant", 32'(bus.issue_grant), 32'd1);
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000);
    #1;
    check("oci0_grant", 32'(bus.issue_grant), 32'd1);
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
    tick();

    // Stall holds the pipeline
    for (int t = 0; t < 4; t++) begin
      drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0010);
      tick();
    end
    check("drain1_counts", 32'(bus.output_channel_counts), 32'd0);
    drive(1'b1, 4'b0100, 1'b0, 1'b0, 4'b0000);
    #1;
    check("st_grant_t0", 32'(bus.issue_grant), 32'd1);
    tick();
    check("st_ifv_t1", 32'(bus.in_flight_valid), 32'b01);
    for (int t = 0; t < 2; t++) begin
      drive(1'b1, 4'b0100, 1'b1, 1'b0, 4'b0000);
      #1;
      check("st_grant_stalled", 32'(bus.issue_grant), 32'd0);
      tick();
      check("st_ifv_held", 32'(bus.in_flight_valid), 32'b01);
      check("st_cnt_held", 32'(bus.output_channel_counts[2]), 32'd0);
    end
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
    tick();
    check("st_ifv_t4", 32'(bus.in_flight_valid), 32'b10);
    check("st_cnt_t4", 32'(bus.output_channel_counts[2]), 32'd0);
    tick();
    check("st_cnt_t5", 32'(bus.output_channel_counts[2]), 32'd1);
    check("st_ifv_t5", 32'(bus.in_flight_valid), 32'b00);

    // Quash discards in-flight writes to channel 3
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0100);
    tick();
    check("drain2_cnt", 32'(bus.output_channel_counts[2]), 32'd0);
    for (int t = 0; t < 2; t++) begin
      drive(1'b1, 4'b1000, 1'b0, 1'b0, 4'b0000);
      tick();
    end
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
    tick();
    tick();
    check("q_cnt_pre", 32'(bus.output_channel_counts[3]), 32'd2);
    for (int t = 0; t < 2; t++) begin
      drive(1'b1, 4'b1000, 1'b0, 1'b0, 4'b0000);
      #1;
      check("q_grant", 32'(bus.issue_grant), 32'd1);
      tick();
    end
    drive(1'b1, 4'b0001, 1'b0, 1'b1, 4'b0000);
    #1;
    check("q_grant_quashed", 32'(bus.issue_grant), 32'd0);
    check("q_full_pre", 32'(bus.output_channel_full_status[3]), 32'd1);
    tick();
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
    #1;
    check("q_ifv", 32'(bus.in_flight_valid), 32'b00);
    check("q_cnt", 32'(bus.output_channel_counts[3]), 32'd2);
    check("q_full", 32'(bus.output_channel_full_status[3]), 32'd0);
    tick();
    tick();
    check("q_cnt_late", 32'(bus.output_channel_counts[3]), 32'd2);

    // Retire + dequeue on the same edge, empty dequeue, bypass grant
    for (int t = 0; t < 2; t++) begin
      drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b1000);
      tick();
    end
    check("drain3_counts", 32'(bus.output_channel_counts), 32'd0);
    for (int t = 0; t < 3; t++) begin
      drive(1'b1, 4'b0001, 1'b0, 1'b0, 4'b0000);
      tick();
    end
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
    tick();
    tick();
    check("rd_cnt_pre", 32'(bus.output_channel_counts[0]), 32'd3);
    drive(1'b1, 4'b0001, 1'b0, 1'b0, 4'b0000);
    tick();
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
    tick();
    drive(1'b1, 4'b0001, 1'b0, 1'b0, 4'b0011);
    #1;
    check("rd_full", 32'(bus.output_channel_full_status[0]), 32'd1);
    check("byp_grant", 32'(bus.issue_grant), 32'(BYP_GRANT));
    tick();
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
    check("rd_cnt0", 32'(bus.output_channel_counts[0]), 32'd3);
    check("rd_cnt1", 32'(bus.output_channel_counts[1]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/output_channel_issue_scheduler.md
Name: output_channel_issue_scheduler

Overview:
Issue-side credit scheduler for PE output channels. It decides cycle by cycle whether an instruction targeting a set of output channels (OCI bit vector) may issue. Capacity counts each channel's committed FIFO occupancy plus writes still in flight through a configurable-depth pipeline, so output FIFOs can never overflow. It sits between the trigger/issue stage and the output channel buffers, and owns the in-flight OCI shift register.

Parameters:
NUM_OUTPUT_CHANNELS, 4, number of output channels (OCI width).
FIFO_DEPTH, 4, entries per output channel buffer.
COUNT_WIDTH, 3, width of per-channel occupancy; must be at least clog2(FIFO_DEPTH+1).
PIPELINE_DEPTH, 2, stages between issue and channel enqueue; must be at least 1.

Ports:
clock  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-low reset.
issue_request  in  1  issue stage holds an instruction wanting to issue.
issue_oci  in  NUM_OUTPUT_CHANNELS  output channels written by that instruction; 0 is legal.
issue_grant  out  1  instruction issues this cycle (combinational).
pipeline_stall  in  1  in-flight stages hold; no issue, no retire.
quash  in  1  squash all in-flight stages without enqueueing.
output_channel_dequeue  in  NUM_OUTPUT_CHANNELS  per-channel pop by downstream consumer.
output_channel_counts  out  NUM_OUTPUT_CHANNELS x COUNT_WIDTH  committed occupancy per channel (registered).
output_channel_full_status  out  NUM_OUTPUT_CHANNELS  effective occupancy is at least FIFO_DEPTH.
in_flight_valid  out  PIPELINE_DEPTH  per-stage flag: stage holds a nonzero OCI.

Behaviour:
- State: occupancy[i] (COUNT_WIDTH) and stage[0..PIPELINE_DEPTH-1] (OCI vectors).
- Reset (reset==0 at edge): all occupancy 0, all stages 0.
- Outputs during and after reset: counts 0, full_status 0, in_flight_valid 0, issue_grant 0 whenever issue_request is 0.
- reset==0 overrides every other input in that cycle. Reset mid-operation discards all in-flight writes.
- inflight[i] = number of stages with bit i set.
- effective[i] = occupancy[i] + inflight[i], computed COUNT_WIDTH+1 bits wide; it never exceeds FIFO_DEPTH in legal operation.
- issue_grant = issue_request & !pipeline_stall & !quash & reset, and for every i with issue_oci[i]=1: effective[i] < FIFO_DEPTH.
- issue_oci of 0 with a request is always granted unless stalled or quashed.
- Multicast is all-or-nothing: one blocked channel denies the whole issue.
- full_status[i] = (effective[i] >= FIFO_DEPTH), combinational from registers only.
- Advance edge (reset=1, stall=0, quash=0):
  - stage[0] <= issue_grant ? issue_oci : 0.
  - stage[k] <= stage[k-1].
  - occupancy[i] += stage[PIPELINE_DEPTH-1][i].
- Stall edge (quash=0): stages hold and no retire. Dequeue still applies.
- Quash edge: all stages <= 0 with no retire. This takes priority over stall. Dequeue still applies.
- Dequeue: occupancy[i] -= 1 when dequeue[i]=1 and occupancy[i]>0. Dequeue of an empty channel is ignored.
- Retire and dequeue on the same channel in the same edge leave occupancy unchanged.
- Latency (PIPELINE_DEPTH=2): grant at cycle T -> full_status reflects it at T+1 -> counts increment visible at T+3. Each stall cycle adds one cycle.
- A dequeue at edge T frees credit visible to grant at T+1. There is no same-cycle bypass unless the optional feature is enabled.

Optional Feature:
OUTPUT_CHANNEL_DEQUEUE_BYPASS_EN.
- Defined: grant compares (effective[i] - (dequeue[i] & occupancy[i]>0)) < FIFO_DEPTH, so a same-cycle pop frees credit immediately. full_status is unchanged (registers only).
- Undefined: behaviour exactly as in Behaviour; the dequeue input does not feed the grant path.

Test Plan:
1. Hold reset=0 for 2 cycles with random inputs -> counts all 0, full_status 0000, in_flight_valid 00. Grant 0 throughout reset.
2. No stall, no dequeue, request oci=0001 every cycle from T0 -> grant 1 at T0..T3 and 0 from T4. full_status[0]=1 from T4. counts[0] reaches 4 at T6 and stays 4.
3. Channel 1 effective=4, channel 0 empty, request oci=0011 -> grant 0, channel 0 state unchanged. Request oci=0001 -> grant 1. Request oci=0000 -> grant 1.
4. Grant oci=0100 at T0, pipeline_stall=1 at T1..T2 -> in_flight_valid held. counts[2] becomes 1 at T5 instead of T3. Grant 0 while stalled.
5. Two grants to channel 3 in flight (counts[3]=2), quash=1 -> next cycle in_flight_valid 00, counts[3] stays 2, full_status[3]=0.
6. counts[0]=3, retire to ch0 and dequeue[0]=1 in the same cycle -> counts[0]=3. dequeue[1] with counts[1]=0 -> counts[1] stays 0. With the bypass macro: effective[0]=4, dequeue[0]=1, request 0001 -> grant 1. Without the macro, the same stimulus -> grant 0.
